// File: rtl/byte_striping_if.sv
// Bus bundle for the two-lane striper: word stream in, two lane words plus status out.
interface byte_striping_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              odd_pending;
  logic [CNT_W-1:0]  pair_cnt;

  modport master (
    output valid_in, data_in,
    input  lane_0, valid_0, lane_1, valid_1, odd_pending, pair_cnt
  );

  modport slave (
    input  valid_in, data_in,
    output lane_0, valid_0, lane_1, valid_1, odd_pending, pair_cnt
  );
endinterface

// File: rtl/byte_striping.sv
// Transmit-side lane striper: alternates valid words onto lane_0/lane_1 and
// holds each lane word for two cycles before clearing it.
module byte_striping #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic            clk_2f,
  input  logic            reset_L,
  byte_striping_if.slave  bus
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } state_t;

  state_t              r_ptr;
  state_t              w_ptrNext;
  logic                w_write0;
  logic                w_write1;

  logic [DATA_W-1:0]   r_lane0;
  logic [DATA_W-1:0]   r_lane1;
  logic                r_valid0;
  logic                r_valid1;
  logic                r_age0;
  logic                r_age1;
  logic [CNT_W-1:0]    r_pairCnt;

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_ptr <= LANE0;
    end else begin
      r_ptr <= w_ptrNext;
    end
  end

  always_comb begin
    w_ptrNext = r_ptr;
    w_write0  = 1'b0;
    w_write1  = 1'b0;
    case (r_ptr)
      LANE0: begin
        if (bus.valid_in) begin
          w_write0  = 1'b1;
          w_ptrNext = LANE1;
        end
      end
      LANE1: begin
        if (bus.valid_in) begin
          w_write1  = 1'b1;
          w_ptrNext = LANE0;
        end
      end
      default: w_ptrNext = LANE0;
    endcase
  end

  // A write restarts the two-cycle window; the second idle cycle clears the lane.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_lane0  <= '0;
      r_valid0 <= 1'b0;
      r_age0   <= 1'b0;
    end else if (w_write0) begin
      r_lane0  <= bus.data_in;
      r_valid0 <= 1'b1;
      r_age0   <= 1'b0;
    end else if (!r_age0) begin
      r_age0   <= 1'b1;
    end else begin
      r_lane0  <= '0;
      r_valid0 <= 1'b0;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_lane1  <= '0;
      r_valid1 <= 1'b0;
      r_age1   <= 1'b0;
    end else if (w_write1) begin
      r_lane1  <= bus.data_in;
      r_valid1 <= 1'b1;
      r_age1   <= 1'b0;
    end else if (!r_age1) begin
      r_age1   <= 1'b1;
    end else begin
      r_lane1  <= '0;
      r_valid1 <= 1'b0;
    end
  end

  // A pair completes when its lane_1 word is written.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_pairCnt <= '0;
    end else if (w_write1) begin
      r_pairCnt <= r_pairCnt + 1'b1;
    end
  end

  assign bus.lane_0      = r_lane0;
  assign bus.valid_0     = r_valid0;
  assign bus.lane_1      = r_lane1;
  assign bus.valid_1     = r_valid1;
  assign bus.odd_pending = (r_ptr == LANE1);
  assign bus.pair_cnt    = r_pairCnt;

endmodule

// File: tb/tb_byte_striping.sv
// Self-checking bench for byte_striping against a timestamp-based lane model.
module tb_byte_striping;

  logic clk_2f;
  logic reset_L;

  byte_striping_if bus ();

  byte_striping dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  int errors = 0;
  int checks = 0;

  // Model: each lane remembers the cycle it was last written; it is visible
  // while fewer than two cycles have elapsed since then.
  int          mCycle;
  int          mWords;
  int          mPairs;
  int          mT0;
  int          mT1;
  logic [31:0] mV0;
  logic [31:0] mV1;

  task automatic modelReset();
    mWords = 0;
    mPairs = 0;
    mT0    = -100;
    mT1    = -100;
    mV0    = '0;
    mV1    = '0;
  endtask

  function automatic logic [74:0] expVec();
    logic        vis0, vis1;
    logic [31:0] l0, l1;
    logic [7:0]  pc;
    vis0 = (mCycle - mT0) <= 1;
    vis1 = (mCycle - mT1) <= 1;
    l0   = vis0 ? mV0 : 32'h0;
    l1   = vis1 ? mV1 : 32'h0;
    pc   = 8'(mPairs % 256);
    return {vis0, l0, vis1, l1, logic'(mWords % 2 == 1), pc};
  endfunction

  function automatic logic [74:0] obsVec();
    return {bus.valid_0, bus.lane_0, bus.valid_1, bus.lane_1,
            bus.odd_pending, bus.pair_cnt};
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk_2f);
    mCycle++;
    if (!reset_L) begin
      modelReset();
    end else if (v) begin
      if (mWords % 2 == 0) begin
        mT0 = mCycle;
        mV0 = d;
      end else begin
        mT1 = mCycle;
        mV1 = d;
        mPairs++;
      end
      mWords++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hFFFF_FFFF);
      checks++;
      if (obsVec() !== 75'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold: got %h expected %h", obsVec(), 75'h0);
      end
    end
    reset_L = 1'b1;
    applyStimulus(1'b1, 32'h1234_5678);
    checks++;
    if (obsVec() !== expVec() || bus.lane_0 !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL reset_release_first_word: got %h expected %h", obsVec(), expVec());
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0BAD_0000 + i);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL reset_followup: got %h expected %h", obsVec(), expVec());
      end
    end
  endtask

  task automatic doReset();
    reset_L = 1'b0;
    applyStimulus(1'b0, 32'h0);
    reset_L = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] words [4];
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    doReset();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) applyStimulus(1'b1, words[i]);
      else       applyStimulus(1'b0, $urandom);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL streaming_cycle%0d: got %h expected %h", i + 1, obsVec(), expVec());
      end
    end
    checks++;
    if (bus.pair_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL streaming_pairs: got %0d expected 2", bus.pair_cnt);
    end
  endtask

  task automatic test_odd_gap();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      applyStimulus(1'b1, 32'hAAAA_0001);
      else if (i == 6) applyStimulus(1'b1, 32'hAAAA_0002);
      else             applyStimulus(1'b0, $urandom);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL odd_gap_cycle%0d: got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      applyStimulus(1'b1, 32'h0000_00B0);
      else if (i == 2) applyStimulus(1'b1, 32'h0000_00B1);
      else             applyStimulus(1'b0, $urandom);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL alternating_cycle%0d: got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_counter_wrap();
    doReset();
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1'b1, $urandom);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, obsVec(), expVec());
      end
    end
    checks++;
    if (bus.pair_cnt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wrap_final: got %h expected 00", bus.pair_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 2) != 0), $urandom);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(1'b1, 32'hC0DE_0001);
    checks++;
    if (bus.odd_pending !== 1'b1 || bus.valid_0 !== 1'b1 || obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL reset_mid_setup: got %h expected %h", obsVec(), expVec());
    end
    #2;
    reset_L = 1'b0;
    modelReset();
    #1;
    checks++;
    if (obsVec() !== 75'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got %h expected %h", obsVec(), 75'h0);
    end
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hD00D_0000 + i);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL reset_mid_after%0d: got %h expected %h", i, obsVec(), expVec());
      end
    end
    checks++;
    if (bus.lane_0 !== 32'hD00D_0002) begin
      errors++;
      $display("[TB] FAIL reset_mid_lane0: got %h expected %h", bus.lane_0, 32'hD00D_0002);
    end
  endtask

  initial begin
    mCycle       = 0;
    modelReset();
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    #2;
    test_reset();
    test_streaming();
    test_odd_gap();
    test_alternating();
    test_counter_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
